// File: rtl/sha256_result_checker.sv
// Small synchronous FIFO with first-word fall-through head and a synchronous clear.
// Latency: a push is visible at the head on the cycle after the write edge.
// Backpressure: push is accepted when not full or when a pop occurs on the same edge.
module checker_fifo #(
    parameter int W     = 41,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic         pop_vld,
    output logic [W-1:0] pop_dat,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    always_comb begin
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_vld  = (wr_ptr_q != rd_ptr_q);
        do_pop   = pop_vld && pop_rdy;
        do_push  = push_vld && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        // Head reads as zero when empty so the outputs are 0 out of reset.
        pop_dat = pop_vld ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end
endmodule

// SHA-256 result checker: nonce tagging, leading-zero difficulty test, hit FIFO, job FSM; CHECKER_HASH_EN adds digest words.
// Latency: found_valid rises 2 cycles after valid_i into an empty FIFO.
// Backpressure: found_valid/found_ready; a hit arriving at a full FIFO without a pop is dropped and sets overflow.
module sha256_result_checker #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             job_start,
    input  logic             job_abort,
    input  logic [31:0]      base_nonce,
    input  logic [CNT_W-1:0] job_count,
    input  logic [7:0]       target_zeros,
    input  logic             valid_i,
    input  logic [31:0]      hash_0,
    input  logic [31:0]      hash_1,
    input  logic [31:0]      hash_2,
    input  logic [31:0]      hash_3,
    input  logic [31:0]      hash_4,
    input  logic [31:0]      hash_5,
    input  logic [31:0]      hash_6,
    input  logic [31:0]      hash_7,
    output logic             found_valid,
    input  logic             found_ready,
    output logic [31:0]      found_nonce,
    output logic [8:0]       found_lzc,
`ifdef CHECKER_HASH_EN
    output logic [31:0]      found_hash_0,
    output logic [31:0]      found_hash_1,
    output logic [31:0]      found_hash_2,
    output logic [31:0]      found_hash_3,
    output logic [31:0]      found_hash_4,
    output logic [31:0]      found_hash_5,
    output logic [31:0]      found_hash_6,
    output logic [31:0]      found_hash_7,
`endif
    output logic             busy,
    output logic             job_done,
    output logic             overflow,
    output logic [CNT_W-1:0] results_cnt
);
`ifdef CHECKER_HASH_EN
    localparam int DW = 41 + 256;
`else
    localparam int DW = 41;
`endif
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    logic [1:0]       state_q, state_d;
    logic [31:0]      nonce_q, nonce_d;
    logic [CNT_W-1:0] results_cnt_q, results_cnt_d, job_cnt_q, job_cnt_d;
    logic             s1_vld_q, s1_vld_d, s1_hit_q, s1_hit_d, s1_last_q, s1_last_d;
    logic [31:0]      s1_nonce_q, s1_nonce_d;
    logic [8:0]       s1_lzc_q, s1_lzc_d;
    logic             job_done_q, job_done_d, overflow_q, overflow_d;
    logic [255:0]     cmp_v;
    logic [8:0]       lzc;
    logic             accept, last, push, fifo_full;
    logic [31:0]      cur_nonce;
    logic [CNT_W-1:0] cur_cnt, cur_target, cnt_next;
    logic [DW-1:0]    push_dat, head_dat;
`ifdef CHECKER_HASH_EN
    logic [255:0]     s1_hash_q, s1_hash_d;
`endif

    always_comb begin
        cmp_v = {bswap(hash_7), bswap(hash_6), bswap(hash_5), bswap(hash_4),
                 bswap(hash_3), bswap(hash_2), bswap(hash_1), bswap(hash_0)};
        // Ascending scan: the most significant set bit is the last to assign.
        lzc = 9'd256;
        for (int i = 0; i < 256; i++) begin
            if (cmp_v[i]) lzc = 9'(255 - i);
        end
    end

    always_comb begin
        // job_start re-bases the job in the same cycle so a coincident valid_i is its first result.
        cur_nonce  = job_start ? base_nonce : nonce_q;
        cur_cnt    = job_start ? '0 : results_cnt_q;
        cur_target = job_start ? job_count : job_cnt_q;
        cnt_next   = cur_cnt + CNT_ONE;
        accept     = valid_i && (job_start || (state_q == ST_RUN && !job_abort));
        last       = accept && (cur_target != '0) && (cnt_next == cur_target);

        state_d = state_q;
        if (job_abort) state_d = ST_IDLE;
        if (job_start) state_d = ST_RUN;
        if (last)      state_d = ST_DONE;

        nonce_d       = accept ? cur_nonce + 32'd1 : cur_nonce;
        results_cnt_d = accept ? cnt_next : cur_cnt;
        job_cnt_d     = cur_target;

        s1_vld_d   = accept;
        s1_hit_d   = (lzc >= {1'b0, target_zeros});
        s1_last_d  = last;
        s1_nonce_d = cur_nonce;
        s1_lzc_d   = lzc;
`ifdef CHECKER_HASH_EN
        s1_hash_d  = {hash_7, hash_6, hash_5, hash_4, hash_3, hash_2, hash_1, hash_0};
        push_dat   = {s1_hash_q, s1_nonce_q, s1_lzc_q};
`else
        push_dat   = {s1_nonce_q, s1_lzc_q};
`endif
        push       = s1_vld_q && s1_hit_q && !job_start && !job_abort;
        job_done_d = s1_vld_q && s1_last_q && !job_start && !job_abort;
        overflow_d = job_start ? 1'b0
                   : (overflow_q || (push && fifo_full && !(found_valid && found_ready)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            nonce_q       <= '0;
            results_cnt_q <= '0;
            job_cnt_q     <= '0;
            s1_vld_q      <= 1'b0;
            s1_hit_q      <= 1'b0;
            s1_last_q     <= 1'b0;
            s1_nonce_q    <= '0;
            s1_lzc_q      <= '0;
            job_done_q    <= 1'b0;
            overflow_q    <= 1'b0;
`ifdef CHECKER_HASH_EN
            s1_hash_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            nonce_q       <= nonce_d;
            results_cnt_q <= results_cnt_d;
            job_cnt_q     <= job_cnt_d;
            s1_vld_q      <= s1_vld_d;
            s1_hit_q      <= s1_hit_d;
            s1_last_q     <= s1_last_d;
            s1_nonce_q    <= s1_nonce_d;
            s1_lzc_q      <= s1_lzc_d;
            job_done_q    <= job_done_d;
            overflow_q    <= overflow_d;
`ifdef CHECKER_HASH_EN
            s1_hash_q     <= s1_hash_d;
`endif
        end
    end

    checker_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (job_start),
        .push_vld (push),
        .push_dat (push_dat),
        .pop_rdy  (found_ready),
        .pop_vld  (found_valid),
        .pop_dat  (head_dat),
        .full     (fifo_full)
    );

    assign found_nonce = head_dat[40:9];
    assign found_lzc   = head_dat[8:0];
`ifdef CHECKER_HASH_EN
    assign found_hash_0 = head_dat[41 +: 32];
    assign found_hash_1 = head_dat[73 +: 32];
    assign found_hash_2 = head_dat[105 +: 32];
    assign found_hash_3 = head_dat[137 +: 32];
    assign found_hash_4 = head_dat[169 +: 32];
    assign found_hash_5 = head_dat[201 +: 32];
    assign found_hash_6 = head_dat[233 +: 32];
    assign found_hash_7 = head_dat[265 +: 32];
`endif
    assign busy        = (state_q == ST_RUN);
    assign job_done    = job_done_q;
    assign overflow    = overflow_q;
    assign results_cnt = results_cnt_q;
endmodule

// File: tb/tb_sha256_result_checker.sv
// Bench for sha256_result_checker: directed vector table, multi-cycle corner sequences, random run against a queue model.
module tb_sha256_result_checker;
    localparam int DEPTH = 4;
    localparam int CNT_W = 32;

    logic              clk = 1'b0;
    logic              rst_n, job_start, job_abort, valid_i, found_ready;
    logic [31:0]       base_nonce;
    logic [CNT_W-1:0]  job_count;
    logic [7:0]        target_zeros;
    logic [7:0][31:0]  hw;
    logic              found_valid, busy, job_done, overflow;
    logic [31:0]       found_nonce;
    logic [8:0]        found_lzc;
    logic [CNT_W-1:0]  results_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sha256_result_checker #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .job_start(job_start), .job_abort(job_abort),
        .base_nonce(base_nonce), .job_count(job_count), .target_zeros(target_zeros),
        .valid_i(valid_i),
        .hash_0(hw[0]), .hash_1(hw[1]), .hash_2(hw[2]), .hash_3(hw[3]),
        .hash_4(hw[4]), .hash_5(hw[5]), .hash_6(hw[6]), .hash_7(hw[7]),
        .found_valid(found_valid), .found_ready(found_ready),
        .found_nonce(found_nonce), .found_lzc(found_lzc),
        .busy(busy), .job_done(job_done), .overflow(overflow), .results_cnt(results_cnt)
    );

    typedef struct packed {
        logic [7:0][31:0] h;
        logic [7:0]       tz;
        logic             hit;
        logic [8:0]       lzc;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] h7, h6, h0, input logic [7:0] tz,
                                input logic hit, input logic [8:0] lzc);
        vec_t v;
        v.h = '0;
        v.h[7] = h7; v.h[6] = h6; v.h[0] = h0;
        v.tz = tz; v.hit = hit; v.lzc = lzc;
        return v;
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Digest compare value read as a big-endian 256-bit number; count zeros by shifting.
    function automatic int ref_lzc(input logic [7:0][31:0] w);
        logic [255:0] v;
        int n;
        v = '0;
        for (int k = 7; k >= 0; k--) v = {v[223:0], bswap(w[k])};
        n = 0;
        while (n < 256 && !v[255]) begin
            v = v << 1;
            n++;
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [31:0] base, input logic [CNT_W-1:0] cnt, input logic [7:0] tz);
        job_start = 1'b1; base_nonce = base; job_count = cnt; target_zeros = tz;
        tick();
        job_start = 1'b0;
    endtask

    task automatic drain_expect(input string name, input logic [31:0] first, input int n);
        logic [31:0] e;
        e = first;
        found_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            chk({name, "_vld"}, 64'(found_valid), 64'd1);
            chk({name, "_nonce"}, 64'(found_nonce), 64'(e));
            e = e + 32'd1;
            tick();
        end
        chk({name, "_empty"}, 64'(found_valid), 64'd0);
        found_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [8];
        int dones, pops;
        logic [40:0] q [$];
        logic [40:0] pend;
        logic        pend_v, m_ovf;
        logic [31:0] m_nonce, w;
        int          m_rcnt, l;
        logic [7:0]  tz;

        vecs[0] = mk(32'h0,        32'hFF000000, 32'h0,        8'd56,  1'b1, 9'd56);
        vecs[1] = mk(32'h0,        32'hFF000000, 32'h0,        8'd57,  1'b0, 9'd56);
        vecs[2] = mk(32'h0,        32'h0,        32'h0,        8'd255, 1'b1, 9'd256);
        vecs[3] = mk(32'h00000080, 32'h0,        32'h0,        8'd0,   1'b1, 9'd0);
        vecs[4] = mk(32'h00000080, 32'h0,        32'h0,        8'd1,   1'b0, 9'd0);
        vecs[5] = mk(32'h01000000, 32'h0,        32'h0,        8'd31,  1'b1, 9'd31);
        vecs[6] = mk(32'h0,        32'h0,        32'h01000000, 8'd255, 1'b1, 9'd255);
        vecs[7] = mk(32'h00F00000, 32'h0,        32'h0,        8'd20,  1'b0, 9'd16);

        rst_n = 1'b0; job_start = 1'b0; job_abort = 1'b0; valid_i = 1'b0; found_ready = 1'b0;
        base_nonce = '0; job_count = '0; target_zeros = '0; hw = '0;
        tick(); tick();
        chk("rst_found_valid", 64'(found_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_job_done", 64'(job_done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_results_cnt", 64'(results_cnt), 64'd0);
        chk("rst_found_nonce", 64'(found_nonce), 64'd0);
        chk("rst_found_lzc", 64'(found_lzc), 64'd0);
        rst_n = 1'b1;
        tick();

        // Three back-to-back results, job_count = 3.
        start_job(32'h10, 3, 8'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        hw = {8{32'hDEADBEEF}};
        valid_i = 1'b1;
        dones = 0;
        tick(); dones += int'(job_done);
        chk("t1_fv_after_1", 64'(found_valid), 64'd0);
        tick(); dones += int'(job_done);
        chk("t1_fv_after_2", 64'(found_valid), 64'd1);
        chk("t1_first_nonce", 64'(found_nonce), 64'h10);
        tick(); dones += int'(job_done);
        chk("t1_busy_drop", 64'(busy), 64'd0);
        for (int c = 0; c < 4; c++) begin
            valid_i = (c == 0);
            tick(); dones += int'(job_done);
        end
        chk("t1_job_done_once", 64'(dones), 64'd1);
        chk("t1_results_cnt", 64'(results_cnt), 64'd3);
        drain_expect("t1_drain", 32'h10, 3);

        // Leading-zero vectors, each presented with valid_i on its job_start cycle.
        for (int i = 0; i < 8; i++) begin
            job_start = 1'b1; base_nonce = 32'h100 + i; job_count = '0;
            target_zeros = vecs[i].tz; hw = vecs[i].h; valid_i = 1'b1;
            tick();
            job_start = 1'b0; valid_i = 1'b0;
            tick();
            chk($sformatf("vec%0d_hit", i), 64'(found_valid), 64'(vecs[i].hit));
            if (vecs[i].hit) begin
                chk($sformatf("vec%0d_lzc", i), 64'(found_lzc), 64'(vecs[i].lzc));
                chk($sformatf("vec%0d_nonce", i), 64'(found_nonce), 64'(32'h100 + i));
            end
            chk($sformatf("vec%0d_cnt", i), 64'(results_cnt), 64'd1);
            found_ready = 1'b1; tick(); found_ready = 1'b0;
        end

        // Six hits into a 4-deep FIFO with no consumer.
        start_job(32'h200, 0, 8'd0);
        valid_i = 1'b1;
        repeat (6) tick();
        valid_i = 1'b0;
        tick(); tick();
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_results_cnt", 64'(results_cnt), 64'd6);
        pops = 0;
        found_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (found_valid) begin
                chk("ovf_pop_nonce", 64'(found_nonce), 64'(32'h200 + pops));
                pops++;
            end
            tick();
        end
        found_ready = 1'b0;
        chk("ovf_pop_count", 64'(pops), 64'd4);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Full FIFO: pop and push on the same edge must not drop.
        start_job(32'h300, 0, 8'd0);
        chk("full_ovf_cleared", 64'(overflow), 64'd0);
        valid_i = 1'b1;
        repeat (4) tick();
        valid_i = 1'b0;
        tick(); tick();
        chk("full_head", 64'(found_nonce), 64'h300);
        valid_i = 1'b1; tick();
        valid_i = 1'b0; found_ready = 1'b1; tick();
        chk("full_pushpop_ovf", 64'(overflow), 64'd0);
        drain_expect("full_drain", 32'h301, 4);

        // Nonce wrap.
        start_job(32'hFFFFFFFE, 0, 8'd0);
        valid_i = 1'b1;
        repeat (3) tick();
        valid_i = 1'b0;
        tick(); tick();
        drain_expect("wrap", 32'hFFFFFFFE, 3);

        // Abort, and start/abort collision.
        start_job(32'h400, 0, 8'd0);
        job_abort = 1'b1; tick(); job_abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        job_start = 1'b1; job_abort = 1'b1; tick();
        job_start = 1'b0; job_abort = 1'b0;
        chk("start_wins_busy", 64'(busy), 64'd1);

        // Reset mid-job with two queued hits, then valid_i while idle.
        start_job(32'h500, 0, 8'd0);
        valid_i = 1'b1; repeat (2) tick();
        valid_i = 1'b0; tick(); tick();
        chk("midrst_pre_fv", 64'(found_valid), 64'd1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("midrst_fv", 64'(found_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ovf", 64'(overflow), 64'd0);
        chk("midrst_cnt", 64'(results_cnt), 64'd0);
        valid_i = 1'b1; tick();
        valid_i = 1'b0; tick(); tick();
        chk("idle_ignored_fv", 64'(found_valid), 64'd0);
        chk("idle_ignored_cnt", 64'(results_cnt), 64'd0);

        // Random traffic with a random consumer, unlimited job.
        tz = 8'($urandom_range(0, 10));
        m_nonce = $urandom;
        start_job(m_nonce, 0, tz);
        q.delete(); pend_v = 1'b0; m_ovf = 1'b0; m_rcnt = 0;
        for (int c = 0; c < 420; c++) begin
            valid_i = (c < 400) && ($urandom_range(0, 1) == 1);
            found_ready = (c >= 400) || ($urandom_range(0, 2) == 0);
            for (int k = 0; k < 8; k++) hw[k] = $urandom;
            w = $urandom >> $urandom_range(0, 31);
            hw[7] = bswap(w);
            if ($urandom_range(0, 7) == 0) begin
                hw[7] = '0;
                hw[6] = bswap(w);
            end
            if (found_ready && q.size() > 0) void'(q.pop_front());
            if (pend_v) begin
                if (q.size() < DEPTH) q.push_back(pend);
                else m_ovf = 1'b1;
            end
            pend_v = 1'b0;
            if (valid_i) begin
                m_rcnt++;
                l = ref_lzc(hw);
                if (l >= int'(tz)) begin
                    pend_v = 1'b1;
                    pend = {m_nonce, 9'(l)};
                end
                m_nonce = m_nonce + 32'd1;
            end
            tick();
            chk("rnd_fv", 64'(found_valid), 64'(q.size() > 0));
            if (q.size() > 0) begin
                chk("rnd_nonce", 64'(found_nonce), 64'(q[0][40:9]));
                chk("rnd_lzc", 64'(found_lzc), 64'(q[0][8:0]));
            end
            chk("rnd_ovf", 64'(overflow), 64'(m_ovf));
            chk("rnd_cnt", 64'(results_cnt), 64'(m_rcnt));
        end
        found_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sha256_result_checker.md
Name: sha256_result_checker

Overview:
- Consumer at the output end of the SHA-256 hashing pipeline.
- Takes the pipeline's valid-qualified 8-word digest stream and assigns each result its nonce by arrival order (the dispatcher issues nonces sequentially from a base).
- Tests each digest against a leading-zero difficulty target and queues hits in a ready/valid result FIFO for the host controller.
- Tracks job progress with a small state machine.

Parameters:
- FIFO_DEPTH, 4, result FIFO entries; power of two, at least 2.
- CNT_W, 32, width of the job result counter and job_count.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- job_start  in  1  one-cycle pulse; loads base_nonce/job_count, enters RUN
- job_abort  in  1  one-cycle pulse; returns to IDLE
- base_nonce  in  32  nonce of the first result of the job
- job_count  in  CNT_W  results expected; 0 = unlimited
- target_zeros  in  8  required leading zero bits, 0..255
- valid_i  in  1  digest valid from the hash pipeline
- hash_0..hash_7  in  32 each  digest words
- found_valid  out  1  FIFO head valid
- found_ready  in  1  consumer accepts head
- found_nonce  out  32  nonce of head entry
- found_lzc  out  9  leading-zero count of head entry, 0..256
- busy  out  1  state == RUN
- job_done  out  1  one-cycle pulse on job completion
- overflow  out  1  sticky; a hit was dropped because the FIFO was full
- results_cnt  out  CNT_W  results accepted in the current job

Behaviour:
- Reset (rst_n low at a clk edge):
  - State IDLE; FIFO empty.
  - All outputs 0: found_valid, busy, job_done, overflow, results_cnt.
  - found_nonce and found_lzc are 0.
- Compare value V (256 bits):
  - V[255:224] = byteswap(hash_7), V[223:192] = byteswap(hash_6), …, V[31:0] = byteswap(hash_0).
  - lzc = number of leading zero bits of V; lzc = 256 when V = 0.
  - Hit when lzc >= target_zeros; target_zeros = 0 makes every result a hit.
  - target_zeros is sampled in stage 1.
- Pipeline:
  - Stage 1 registers valid, nonce and lzc at the edge where valid_i is high.
  - Stage 2 writes the FIFO on the next edge.
  - found_valid rises exactly 2 cycles after valid_i when the FIFO was empty (first-word fall-through).
- Nonce assignment:
  - A nonce counter loads base_nonce on job_start.
  - It increments by 1 on each accepted result and wraps from 0xFFFFFFFF to 0x00000000.
- State machine:
  - IDLE: valid_i is ignored. job_start -> RUN.
  - RUN: each valid_i is accepted; results_cnt increments.
    - When results_cnt reaches job_count (job_count != 0): go to DONE; job_done pulses on the same edge as that result's FIFO write.
    - job_abort -> IDLE.
    - job_start -> RUN (restart).
  - DONE: valid_i is ignored. job_start -> RUN; job_abort -> IDLE.
- job_start side effects:
  - Clears the FIFO, overflow, results_cnt, and stage-1/stage-2 valids.
  - valid_i in the same cycle as job_start is accepted as the first result of the new job, with nonce = base_nonce.
  - The controller drains stale pipeline results before issuing job_start.
- job_abort: clears the stage valids; the FIFO contents are retained.
- job_start and job_abort in the same cycle: job_start wins.
- FIFO:
  - Pop on found_valid && found_ready.
  - Push and pop in the same cycle while full: both occur and no drop.
  - Push while full without a pop: the hit is dropped and overflow is set (sticky until job_start or reset).
  - found_* outputs are stable while found_valid && !found_ready.
- Reset mid-job: immediate return to IDLE; all pending hits are lost.

Optional Feature:
- Macro: CHECKER_HASH_EN.
- Defined:
  - The FIFO additionally stores the 8 digest words.
  - Extra output ports found_hash_0..found_hash_7 (32 bits each, reset 0) present the head entry's digest unmodified.
- Undefined:
  - These ports and their storage do not exist.
  - FIFO width is 41 bits (nonce + lzc).

Test Plan:
- Reset then job_start with base_nonce=0x10, job_count=3, target_zeros=0; three back-to-back valid_i -> found_nonce 0x10, 0x11, 0x12 in order; first found_valid 2 cycles after the first valid_i; job_done pulses once; busy drops; results_cnt=3.
- target_zeros=56; hash_7=0x00000000, hash_6=0xFF000000 -> lzc=56, hit queued. Same stimulus with target_zeros=57 -> no entry; results_cnt still increments.
- FIFO_DEPTH=4, found_ready=0, six hits -> four entries kept (nonces base..base+3), overflow=1. Release found_ready -> exactly four pops.
- Full FIFO with found_ready=1 and a new hit in the same cycle -> pop plus push, no overflow.
- base_nonce=0xFFFFFFFE, two hits -> nonces 0xFFFFFFFE, 0xFFFFFFFF; a third hit -> 0x00000000.
- rst_n low mid-job with 2 FIFO entries -> next cycle found_valid=0, busy=0, overflow=0. valid_i while IDLE -> ignored; results_cnt stays 0.
